spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave: synchronises the SPI pins into i_Clk, shifts bytes in on SCLK rise,
// shifts the TX byte out on SCLK fall, and reports frame and byte status.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_MOSI,
  input  logic       i_SPI_CS_n,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_Frame_Err,
  output logic [7:0] o_Byte_Cnt
);

  // state     | meaning
  // ST_IDLE   | synchronised CS_n high, SPI edges ignored, MISO quiet
  // ST_ACTIVE | synchronised CS_n low, shifting RX and TX
  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic       r_sclk_d, r_cs_d;
  logic       w_sclk_s, w_cs_s, w_mosi_s;
  logic       r_sclk_rise_p, r_sclk_fall_p, r_cs_fall_p, r_cs_rise_p, r_mosi_d;
  logic       w_start, w_stop, w_shift_rx, w_shift_tx, w_reload;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift, r_tx_shift, r_tx_buf;
  logic       r_tx_full, r_byte_done, r_frame_err, r_rx_dv;
  logic [7:0] r_rx_byte, r_byte_cnt;
  logic       w_miso, w_miso_en;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  // Edge pulses are registered together with MOSI so every event lands in the same cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sclk_rise_p <= 1'b0;
      r_sclk_fall_p <= 1'b0;
      r_cs_fall_p   <= 1'b0;
      r_cs_rise_p   <= 1'b0;
      r_mosi_d      <= 1'b0;
    end else begin
      r_sclk_rise_p <= w_sclk_s & ~r_sclk_d;
      r_sclk_fall_p <= ~w_sclk_s & r_sclk_d;
      r_cs_fall_p   <= ~w_cs_s & r_cs_d;
      r_cs_rise_p   <= w_cs_s & ~r_cs_d;
      r_mosi_d      <= w_mosi_s;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (r_cs_fall_p) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (r_cs_rise_p) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_miso_en = 1'b0;
    w_miso    = 1'b0;
    if (r_state == ST_ACTIVE) begin
      w_miso_en = 1'b1;
      w_miso    = r_tx_shift[7];
    end
  end

  // A CS rise in the same cycle as an SCLK edge suppresses the edge.
  assign w_start    = (r_state == ST_IDLE) & r_cs_fall_p;
  assign w_stop     = (r_state == ST_ACTIVE) & r_cs_rise_p;
  assign w_shift_rx = (r_state == ST_ACTIVE) & ~r_cs_rise_p & r_sclk_rise_p;
  assign w_shift_tx = (r_state == ST_ACTIVE) & ~r_cs_rise_p & r_sclk_fall_p;
  assign w_reload   = w_start | (w_shift_tx & (r_bit_cnt == 3'd0));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_bit_cnt   <= 3'd0;
      r_rx_shift  <= 8'h00;
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= 3'd0;
      end else if (w_stop) begin
        r_bit_cnt   <= 3'd0;
        r_frame_err <= (r_bit_cnt != 3'd0);
      end else if (w_shift_rx) begin
        r_rx_shift  <= {r_rx_shift[6:0], r_mosi_d};
        r_bit_cnt   <= r_bit_cnt + 3'd1;
        r_byte_done <= (r_bit_cnt == 3'd7);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rx_dv    <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_byte_cnt <= 8'h00;
    end else begin
      r_rx_dv <= r_byte_done;
      if (r_byte_done) r_rx_byte <= r_rx_shift;
      if (w_start)          r_byte_cnt <= 8'h00;
      else if (r_byte_done) r_byte_cnt <= r_byte_cnt + 8'd1;
    end
  end

  // A new strobe always lands in the buffer, even when the old content is leaving on a reload.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tx_shift <= 8'h00;
      r_tx_buf   <= 8'h00;
      r_tx_full  <= 1'b0;
    end else begin
      if (w_reload)        r_tx_shift <= r_tx_full ? r_tx_buf : 8'h00;
      else if (w_shift_tx) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      if (i_TX_DV) begin
        r_tx_buf  <= i_TX_Byte;
        r_tx_full <= 1'b1;
      end else if (w_reload) begin
        r_tx_full <= 1'b0;
      end
    end
  end

  assign o_SPI_MISO    = w_miso;
  assign o_SPI_MISO_En = w_miso_en;
  assign o_RX_DV       = r_rx_dv;
  assign o_RX_Byte     = r_rx_byte;
  assign o_TX_Ready    = ~r_tx_full;
  assign o_Frame_Err   = r_frame_err;
  assign o_Byte_Cnt    = r_byte_cnt;

endmodule
